// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl: parametrised Wishbone GPIO controller.
// GPIO_WIDTH pins with synchronised inputs, an OUT register with atomic SET/CLR
// aliases, a DIR register and optional per-pin edge interrupts.
//
// Optional feature macro: GPIO_IRQ_EN. When it is defined, MASK/POL/STAT, the edge
// detector and irq_o are built. When it is undefined, addresses 5..7 read 0, writes
// to them are acked and dropped, and irq_o is tied low.
//
// Ports:
//   clock       bus clock, rising edge
//   reset_n     asynchronous reset, active low
//   wb_adr_i    word address (bus adr[4:2])
//   wb_dat_i    write data
//   wb_sel_i    byte enables
//   wb_we_i     write strobe
//   wb_cyc_i    bus cycle
//   wb_stb_i    strobe
//   wb_dat_o    read data, valid while wb_ack_o is high
//   wb_ack_o    one-cycle acknowledge
//   gpio_i      pad inputs, asynchronous to clock
//   gpio_o      OUT register
//   gpio_dir_o  DIR register, 1 = output
//   irq_o       level interrupt
module wb_gpio_ctrl #(
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_dir_o,
  output logic                  irq_o
);

  localparam logic [2:0] AdrIn   = 3'd0;
  localparam logic [2:0] AdrOut  = 3'd1;
  localparam logic [2:0] AdrDir  = 3'd2;
  localparam logic [2:0] AdrSet  = 3'd3;
  localparam logic [2:0] AdrClr  = 3'd4;
  localparam logic [2:0] AdrMask = 3'd5;
  localparam logic [2:0] AdrPol  = 3'd6;
  localparam logic [2:0] AdrStat = 3'd7;

  logic                  ack_q;
  logic [31:0]           dat_q, rdata;
  logic [GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] sync;
  logic [GPIO_WIDTH-1:0] mask_rd, pol_rd, stat_rd;
  logic [31:0]           be, wdat_full;
  logic [GPIO_WIDTH-1:0] wmask, wdat;
  logic                  access, wr_en;
  logic                  unused_wdat;

  // ack blocks a new access, so every transfer takes two cycles.
  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en  = access & wb_we_i;

  always_comb begin
    for (int i = 0; i < 4; i++) be[8*i +: 8] = {8{wb_sel_i[i]}};
  end

  assign wdat_full   = wb_dat_i & be;
  assign wmask       = be[GPIO_WIDTH-1:0];
  assign wdat        = wdat_full[GPIO_WIDTH-1:0];
  assign unused_wdat = ^wdat_full;

  // Input synchroniser; IN sees a pad change SYNC_STAGES edges later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en) begin
      case (wb_adr_i)
        AdrOut:  out_d = (out_q & ~wmask) | wdat;
        AdrDir:  dir_d = (dir_q & ~wmask) | wdat;
        AdrSet:  out_d = out_q | wdat;
        AdrClr:  out_d = out_q & ~wdat;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      AdrIn:   rdata[GPIO_WIDTH-1:0] = sync;
      AdrOut:  rdata[GPIO_WIDTH-1:0] = out_q;
      AdrDir:  rdata[GPIO_WIDTH-1:0] = dir_q;
      AdrMask: rdata[GPIO_WIDTH-1:0] = mask_rd;
      AdrPol:  rdata[GPIO_WIDTH-1:0] = pol_rd;
      AdrStat: rdata[GPIO_WIDTH-1:0] = stat_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      out_q <= OUT_RESET;
      dir_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= access ? rdata : '0;
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] mask_q, mask_d, pol_q, pol_d, stat_q, stat_d, prev_q, ev;
  logic                  irq_q;

  // Events depend only on sync/prev history, so a POL write cannot fake an edge.
  assign ev = (pol_q & sync & ~prev_q) | (~pol_q & ~sync & prev_q);

  always_comb begin
    mask_d = mask_q;
    pol_d  = pol_q;
    stat_d = stat_q;
    if (wr_en) begin
      case (wb_adr_i)
        AdrMask: mask_d = (mask_q & ~wmask) | wdat;
        AdrPol:  pol_d  = (pol_q & ~wmask) | wdat;
        AdrStat: stat_d = stat_q & ~wdat;
        default: ;
      endcase
    end
    // A new edge wins over a simultaneous W1C.
    stat_d = stat_d | ev;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      prev_q <= sync;
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign pol_rd  = pol_q;
  assign stat_rd = stat_q;
  assign irq_o   = irq_q;
`else
  assign mask_rd = '0;
  assign pol_rd  = '0;
  assign stat_rd = '0;
  assign irq_o   = 1'b0;
`endif

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign gpio_o     = out_q;
  assign gpio_dir_o = dir_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Testbench for wb_gpio_ctrl (GPIO_WIDTH=8, SYNC_STAGES=2, OUT_RESET=8'hA5).
// A cycle model tracks register contents and pad history; outputs are compared
// against it on every falling edge, plus literal checks from directed vectors.
module tb_wb_gpio_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  gpio_i, gpio_o, gpio_dir_o;
  logic        irq_o;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  wb_gpio_ctrl #(
    .GPIO_WIDTH (8),
    .SYNC_STAGES(2),
    .OUT_RESET  (8'hA5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_dir_o(gpio_dir_o),
    .irq_o     (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [7:0]  out, dir, mask, pol, stat;
    logic        irq, ack;
    logic [31:0] dat;
    logic [7:0]  h0, h1, h2;  // pad value 1, 2 and 3 edges ago
  } mdl_t;

  localparam mdl_t MdlRst = '{out: 8'hA5, default: '0};

`ifdef GPIO_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  function automatic logic [31:0] model_read(mdl_t s, logic [2:0] adr);
    case (adr)
      3'd0: return {24'h0, s.h1};
      3'd1: return {24'h0, s.out};
      3'd2: return {24'h0, s.dir};
      3'd5: return IrqEn ? {24'h0, s.mask} : 32'h0;
      3'd6: return IrqEn ? {24'h0, s.pol} : 32'h0;
      3'd7: return IrqEn ? {24'h0, s.stat} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic mdl_t step(mdl_t s, logic [2:0] adr, logic [31:0] di, logic [3:0] sel,
                                logic we, logic cyc, logic stb, logic [7:0] pad);
    mdl_t       n;
    logic [7:0] m, wd, ev;
    logic       acc;
    n   = s;
    m   = {8{sel[0]}};
    wd  = di[7:0] & m;
    acc = cyc && stb && !s.ack;
    ev  = '0;
    // An event is a synchronised level change whose new level matches POL.
    for (int b = 0; b < 8; b++)
      if (s.h1[b] != s.h2[b] && s.h1[b] == s.pol[b]) ev[b] = 1'b1;
    n.ack = acc;
    n.dat = acc ? model_read(s, adr) : 32'h0;
    n.irq = IrqEn && ((s.stat & s.mask) != 0);
    if (acc && we) begin
      case (adr)
        3'd1: n.out = (s.out & ~m) | wd;
        3'd2: n.dir = (s.dir & ~m) | wd;
        3'd3: n.out = s.out | wd;
        3'd4: n.out = s.out & ~wd;
        3'd5: if (IrqEn) n.mask = (s.mask & ~m) | wd;
        3'd6: if (IrqEn) n.pol = (s.pol & ~m) | wd;
        3'd7: if (IrqEn) n.stat = s.stat & ~wd;
        default: ;
      endcase
    end
    if (IrqEn) n.stat = n.stat | ev;
    n.h2 = s.h1;
    n.h1 = s.h0;
    n.h0 = pad;
    return n;
  endfunction

  mdl_t mdl;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mdl <= MdlRst;
    else mdl <= step(mdl, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, gpio_i);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_gpio_o", {24'h0, gpio_o}, {24'h0, mdl.out});
      check("m_dir", {24'h0, gpio_dir_o}, {24'h0, mdl.dir});
      check("m_irq", {31'h0, irq_o}, {31'h0, mdl.irq});
      check("m_ack", {31'h0, wb_ack_o}, {31'h0, mdl.ack});
      if (wb_ack_o && !wb_we_i) check("m_rdata", wb_dat_o, mdl.dat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge following the ack.
  task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd);
    bit got = 1'b0;
    rd       = '0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = d;
    wb_sel_i = sel;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clock);
      #1;
      if (wb_ack_o) begin
        got = 1'b1;
        rd  = wb_dat_o;
      end
    end
    if (!got) check("ack_timeout", 32'h0, 32'h1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    reset_n  = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    gpio_i   = '0;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_gpio_o", {24'h0, gpio_o}, 32'hA5);
    check("rst_dir", {24'h0, gpio_dir_o}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    reset_n = 1'b1;
    idle(1);

    bus(1'b0, 3'd1, 32'h0, 4'hF, rd);
    check("rd_out_reset", rd, 32'h0000_00A5);
    bus(1'b1, 3'd1, 32'hFFFF_FF3C, 4'b0001, rd);
    check("wr_out_lane0", {24'h0, gpio_o}, 32'h3C);
    bus(1'b1, 3'd3, 32'h03, 4'hF, rd);
    check("set", {24'h0, gpio_o}, 32'h3F);
    bus(1'b1, 3'd4, 32'h30, 4'hF, rd);
    check("clr", {24'h0, gpio_o}, 32'h0F);
    bus(1'b0, 3'd3, 32'h0, 4'hF, rd);
    check("rd_set_zero", rd, 32'h0);
    bus(1'b1, 3'd2, 32'h0000_F0F0, 4'b0000, rd);
    check("dir_no_sel", {24'h0, gpio_dir_o}, 32'h0);
    bus(1'b1, 3'd2, 32'h0000_F0F0, 4'b0001, rd);
    check("dir_lane0", {24'h0, gpio_dir_o}, 32'hF0);
    bus(1'b0, 3'd2, 32'h0, 4'hF, rd);
    check("rd_dir", rd, 32'h0000_00F0);

    // Pad change and read launched together: the sampling edge precedes synchronisation.
    gpio_i = 8'h81;
    bus(1'b0, 3'd0, 32'h0, 4'hF, rd);
    check("in_early", rd, 32'h0);
    bus(1'b0, 3'd0, 32'h0, 4'hF, rd);
    check("in_late", rd, 32'h81);
    bus(1'b1, 3'd0, 32'hFF, 4'hF, rd);
    bus(1'b0, 3'd0, 32'h0, 4'hF, rd);
    check("in_ro", rd, 32'h81);

`ifdef GPIO_IRQ_EN
    gpio_i = 8'h00;
    idle(4);
    bus(1'b1, 3'd7, 32'hFF, 4'hF, rd);
    bus(1'b1, 3'd5, 32'h01, 4'hF, rd);
    bus(1'b1, 3'd6, 32'h01, 4'hF, rd);
    bus(1'b0, 3'd7, 32'h0, 4'hF, rd);
    check("stat_cleared", rd, 32'h0);
    gpio_i = 8'h01;
    idle(4);
    bus(1'b0, 3'd7, 32'h0, 4'hF, rd);
    check("stat_rise", rd, 32'h01);
    check("irq_set", {31'h0, irq_o}, 32'h1);
    bus(1'b1, 3'd7, 32'h01, 4'hF, rd);
    check("irq_after_w1c", {31'h0, irq_o}, 32'h0);
    gpio_i = 8'h00;
    idle(4);
    bus(1'b0, 3'd7, 32'h0, 4'hF, rd);
    check("stat_fall_ignored", rd, 32'h0);
    gpio_i = 8'h01;
    idle(4);
    gpio_i = 8'h00;
    idle(4);
    check("irq_before_race", {31'h0, irq_o}, 32'h1);
    // Edge reaches sync two edges after the pad change, the W1C lands on the third.
    gpio_i = 8'h01;
    idle(2);
    bus(1'b1, 3'd7, 32'h01, 4'hF, rd);
    check("irq_race", {31'h0, irq_o}, 32'h1);
    bus(1'b0, 3'd7, 32'h0, 4'hF, rd);
    check("stat_race", rd, 32'h01);
`else
    for (int a = 5; a < 8; a++) begin
      bus(1'b1, 3'(a), 32'hFF, 4'hF, rd);
      bus(1'b0, 3'(a), 32'h0, 4'hF, rd);
      check("noirq_rd0", rd, 32'h0);
    end
    gpio_i = 8'h00;
    idle(4);
    check("noirq_irq0", {31'h0, irq_o}, 32'h0);
`endif

    // Reset while a write is pending: the write is lost.
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 3'd1;
    wb_dat_i = 32'h55;
    wb_sel_i = 4'hF;
    #2 reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("midrst_out", {24'h0, gpio_o}, 32'hA5);
    check("midrst_dir", {24'h0, gpio_dir_o}, 32'h0);
    check("midrst_irq", {31'h0, irq_o}, 32'h0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    reset_n  = 1'b1;
    idle(1);
    bus(1'b0, 3'd7, 32'h0, 4'hF, rd);
    check("stat_after_rst", rd, 32'h0);
    check("irq_after_rst", {31'h0, irq_o}, 32'h0);
    bus(1'b0, 3'd1, 32'h0, 4'hF, rd);
    check("out_after_rst", rd, 32'h0000_00A5);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
